// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modexp_pkg
// Description : Shared types and constants for the modexp32 engine. It
//               holds the FSM state encoding, the engine-operation encoding,
//               the operand width and the engine timeout limit.
// Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

    localparam int OPW            = 32;
    localparam int TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_REL  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_RED = 2'd0,
        OP_MUL = 2'd1,
        OP_SQR = 2'd2
    } op_e;

endpackage : modexp_pkg
`default_nettype wire

// File: rtl/modexp32.sv
`default_nettype none
// ============================================================================
// Module      : modexp32
// Description : 32-bit modular exponentiation, result = base^exp mod modulus,
//               using right-to-left square-and-multiply. Every reduction is
//               delegated to an external mod64 engine through an en/rdy
//               handshake in which this block is the initiator.
// Ports       : clk, rst (async, active-high)
//               start, base, exp, modulus     - request and operands
//               busy, done, result, err       - status and result
//               mod_en, mod_din, mod_m        - engine request and operands
//               mod_rdy, mod_out              - engine status and remainder
// Config      : MODEXP_TIMEOUT_EN - when defined, each engine transaction is
//               aborted after TIMEOUT_CYCLES cycles in REQ+WAIT and err
//               pulses; when undefined err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp32
    import modexp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   base,
    input  logic [OPW-1:0]   exp,
    input  logic [OPW-1:0]   modulus,
    output logic             busy,
    output logic             done,
    output logic [OPW-1:0]   result,
    output logic             err,
    output logic             mod_en,
    output logic [2*OPW-1:0] mod_din,
    output logic [2*OPW-1:0] mod_m,
    input  logic             mod_rdy,
    input  logic [2*OPW-1:0] mod_out
);

    state_e             state_q;
    op_e                op_q;
    logic [OPW-1:0]     exp_q;
    logic [OPW-1:0]     r_q;
    logic [OPW-1:0]     b_q;
    logic               fin_q;      // trivial modulus: finish without engine
    logic               busy_q;
    logic               done_q;
    logic [OPW-1:0]     result_q;
    logic               mod_en_q;
    logic [2*OPW-1:0]   mod_din_q;
    logic [2*OPW-1:0]   mod_m_q;

    // Remainders never exceed the 32-bit modulus, so the upper half is unused.
    logic               unused_mod_out_hi;
    assign unused_mod_out_hi = ^mod_out[2*OPW-1:OPW];

    // Next-operation selection, evaluated in REL after a remainder has been
    // captured. exp_q is shifted when a SQR completes, so exp_q[0] is always
    // the bit about to be processed.
    op_e                op_d;
    logic               fin_d;
    logic [2*OPW-1:0]   din_d;

    always_comb begin
        op_d  = OP_SQR;
        fin_d = 1'b0;
        unique case (op_q)
            OP_RED: begin
                if (exp_q == '0)
                    fin_d = 1'b1;
                else if (exp_q[0])
                    op_d = OP_MUL;
            end
            OP_MUL: begin
                // No squaring is needed once the remaining exponent is zero.
                if (exp_q[OPW-1:1] == '0)
                    fin_d = 1'b1;
            end
            default: begin
                if (exp_q[0])
                    op_d = OP_MUL;
            end
        endcase
        if (fin_q)
            fin_d = 1'b1;
        if (op_d == OP_MUL)
            din_d = {{OPW{1'b0}}, r_q} * {{OPW{1'b0}}, b_q};
        else
            din_d = {{OPW{1'b0}}, b_q} * {{OPW{1'b0}}, b_q};
    end

`ifdef MODEXP_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RED;
            exp_q     <= '0;
            r_q       <= '0;
            b_q       <= '0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            mod_en_q  <= 1'b0;
            mod_din_q <= '0;
            mod_m_q   <= '0;
`ifdef MODEXP_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MODEXP_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        exp_q  <= exp;
                        r_q    <= OPW'(1);
                        b_q    <= '0;
                        op_q   <= OP_RED;
                        if (modulus < OPW'(2)) begin
                            fin_q   <= 1'b1;
                            state_q <= ST_REL;
                        end else begin
                            fin_q     <= 1'b0;
                            mod_din_q <= {{OPW{1'b0}}, base};
                            mod_m_q   <= {{OPW{1'b0}}, modulus};
                            mod_en_q  <= 1'b1;
                            state_q   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (!mod_rdy)
                        state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mod_rdy) begin
                        mod_en_q <= 1'b0;
                        state_q  <= ST_REL;
                        unique case (op_q)
                            OP_MUL: r_q <= mod_out[OPW-1:0];
                            OP_SQR: begin
                                b_q   <= mod_out[OPW-1:0];
                                exp_q <= exp_q >> 1;
                            end
                            default: b_q <= mod_out[OPW-1:0];
                        endcase
                    end
                end
                ST_REL: begin
                    if (fin_d) begin
                        result_q <= fin_q ? '0 : r_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else begin
                        op_q      <= op_d;
                        mod_din_q <= din_d;
                        mod_en_q  <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mod_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
`ifdef MODEXP_TIMEOUT_EN
            // Per-transaction watchdog; a completing WAIT wins over the abort.
            if (state_q == ST_REQ || state_q == ST_WAIT) begin
                if (tmo_cnt_q == TMO_LAST && !(state_q == ST_WAIT && mod_rdy)) begin
                    state_q   <= ST_IDLE;
                    mod_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    err_q     <= 1'b1;
                    tmo_cnt_q <= '0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                end
            end else begin
                tmo_cnt_q <= '0;
            end
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign mod_en  = mod_en_q;
    assign mod_din = mod_din_q;
    assign mod_m   = mod_m_q;
`ifdef MODEXP_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule : modexp32
`default_nettype wire

// File: tb/tb_modexp32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_modexp32
// Description : Self-checking bench for modexp32 with a mod64 engine stub
//               and a plain-arithmetic modular exponentiation model.
//               MODEXP_TIMEOUT_EN selects the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_v = '0, exp_v = '0, mod_v = '0;
    logic        busy, done, err, mod_en, mod_rdy;
    logic [31:0] result;
    logic [63:0] mod_din, mod_m, mod_out;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    modexp32 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base_v),
        .exp     (exp_v),
        .modulus (mod_v),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err),
        .mod_en  (mod_en),
        .mod_din (mod_din),
        .mod_m   (mod_m),
        .mod_rdy (mod_rdy),
        .mod_out (mod_out)
    );

    // ---------------- mod64 engine stub ----------------
    logic            hold_rdy = 1'b0;   // never start computing
    logic            stub_slow = 1'b0;  // long fixed latency
    int              stub_st, stub_lat;
    logic [63:0]     lat_din, lat_m;
    longint unsigned din_log[$];
    int              proto_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_rdy <= 1'b1;
            mod_out <= '0;
            stub_st <= 0;
            stub_lat <= 0;
        end else begin
            case (stub_st)
                0: if (mod_en && !hold_rdy) begin
                    mod_rdy  <= 1'b0;
                    lat_din  <= mod_din;
                    lat_m    <= mod_m;
                    stub_lat <= stub_slow ? 6 : int'($urandom_range(0, 3));
                    stub_st  <= 1;
                    din_log.push_back(mod_din);
                end
                1: begin
                    if (mod_din !== lat_din || mod_m !== lat_m || mod_en !== 1'b1)
                        proto_err <= proto_err + 1;
                    if (stub_lat == 0) begin
                        mod_out <= (lat_m == 0) ? 64'd0 : lat_din % lat_m;
                        mod_rdy <= 1'b1;
                        stub_st <= 2;
                    end else begin
                        stub_lat <= stub_lat - 1;
                    end
                end
                default: if (!mod_en) stub_st <= 0;
            endcase
        end
    end

    // ---------------- passive monitor ----------------
    int en_hi = 0, both_hi = 0, err_hi = 0;
    always @(negedge clk) begin
        if (mod_en === 1'b1) en_hi <= en_hi + 1;
        if (done === 1'b1 && err === 1'b1) both_hi <= both_hi + 1;
        if (err === 1'b1) err_hi <= err_hi + 1;
    end

    // ---------------- reference model ----------------
    longint unsigned exp_din[$];

    task automatic model(input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] m, output logic [31:0] res);
        longint unsigned r, bb, ee, mm;
        exp_din.delete();
        mm = {32'd0, m};
        if (m < 2) begin
            res = '0;
            return;
        end
        exp_din.push_back({32'd0, b});
        bb = {32'd0, b} % mm;
        r  = 1;
        ee = {32'd0, e};
        while (ee != 0) begin
            if (ee[0]) begin
                exp_din.push_back(r * bb);
                r = (r * bb) % mm;
            end
            ee = ee >> 1;
            if (ee != 0) begin
                exp_din.push_back(bb * bb);
                bb = (bb * bb) % mm;
            end
        end
        res = r[31:0];
    endtask

    // Issue one request and wait (bounded) for done.
    task automatic run_op(input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] m, output logic [31:0] res,
                          output int cyc, output logic busy1, output logic got,
                          output int idx0, output int ntx);
        idx0 = din_log.size();
        @(negedge clk);
        base_v = b; exp_v = e; mod_v = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        got = (done === 1'b1);
        res = result;
        ntx = din_log.size() - idx0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({busy, done, err, mod_en} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, err, mod_en});
        end
        nvec++;
        if (result !== 32'd0 || mod_din !== 64'd0 || mod_m !== 64'd0) begin
            nerr++;
            $display("FAIL reset_data: got result=%h din=%h m=%h want all zero", result, mod_din, mod_m);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] tb_b[4] = '{32'd4, 32'd2, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] tb_e[4] = '{32'd13, 32'd10, 32'd0, 32'd2};
        logic [31:0] tb_m[4] = '{32'd497, 32'd1000, 32'd7, 32'hFFFF_FFFB};
        logic [31:0] tb_r[4] = '{32'd445, 32'd24, 32'd1, 32'd16};
        int          tb_n[4] = '{7, 6, 1, 3};
        logic [31:0] res, mres;
        logic        busy1, got;
        int          cyc, idx0, ntx, bad;
        for (int i = 0; i < 4; i++) begin
            model(tb_b[i], tb_e[i], tb_m[i], mres);
            run_op(tb_b[i], tb_e[i], tb_m[i], res, cyc, busy1, got, idx0, ntx);
            nvec++;
            if (!got || res !== tb_r[i]) begin
                nerr++;
                $display("FAIL dir_result[%0d]: got %0d (done=%0b) want %0d", i, res, got, tb_r[i]);
            end
            nvec++;
            if (ntx !== tb_n[i]) begin
                nerr++;
                $display("FAIL dir_txns[%0d]: got %0d want %0d", i, ntx, tb_n[i]);
            end
            bad = 0;
            for (int k = 0; k < exp_din.size() && k < ntx; k++)
                if (din_log[idx0 + k] !== exp_din[k]) bad++;
            nvec++;
            if (bad != 0 || ntx != exp_din.size()) begin
                nerr++;
                $display("FAIL dir_operands[%0d]: %0d operand errors, %0d txns want %0d", i, bad, ntx, exp_din.size());
            end
            nvec++;
            if (busy1 !== 1'b1) begin
                nerr++;
                $display("FAIL dir_busy[%0d]: got %b want 1", i, busy1);
            end
        end
    endtask

    task automatic test_trivial_modulus();
        logic [31:0] res;
        logic        busy1, got;
        int          cyc, idx0, ntx, en0;
        for (int i = 0; i < 2; i++) begin
            en0 = en_hi;
            run_op($urandom, $urandom, i, res, cyc, busy1, got, idx0, ntx);
            nvec++;
            if (!got || res !== 32'd0) begin
                nerr++;
                $display("FAIL triv_result[m=%0d]: got %0d (done=%0b) want 0", i, res, got);
            end
            nvec++;
            if (cyc != 2) begin
                nerr++;
                $display("FAIL triv_latency[m=%0d]: got %0d cycles want 2", i, cyc);
            end
            nvec++;
            if (en_hi != en0 || ntx != 0) begin
                nerr++;
                $display("FAIL triv_no_engine[m=%0d]: got %0d mod_en cycles, %0d txns want 0", i, en_hi - en0, ntx);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] b, e, m, res, mres;
        logic        busy1, got;
        int          cyc, idx0, ntx, bad;
        for (int i = 0; i < 12; i++) begin
            b = $urandom;
            e = (i % 3 == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            m = (i % 2 == 0) ? 32'($urandom_range(2, 1000)) : ($urandom | 32'h8000_0000);
            model(b, e, m, mres);
            run_op(b, e, m, res, cyc, busy1, got, idx0, ntx);
            nvec++;
            if (!got || res !== mres) begin
                nerr++;
                $display("FAIL rnd_result[%0d]: %0d^%0d mod %0d got %0d (done=%0b) want %0d", i, b, e, m, res, got, mres);
            end
            bad = 0;
            for (int k = 0; k < exp_din.size() && k < ntx; k++)
                if (din_log[idx0 + k] !== exp_din[k]) bad++;
            nvec++;
            if (bad != 0 || ntx != exp_din.size()) begin
                nerr++;
                $display("FAIL rnd_operands[%0d]: %0d operand errors, %0d txns want %0d", i, bad, ntx, exp_din.size());
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] mres;
        int          cyc, idx0;
        model(32'd7, 32'd77, 32'd991, mres);
        idx0 = din_log.size();
        @(negedge clk);
        base_v = 32'd7; exp_v = 32'd77; mod_v = 32'd991; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        base_v = 32'd5; exp_v = 32'd3; mod_v = 32'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        nvec++;
        if (done !== 1'b1 || result !== mres) begin
            nerr++;
            $display("FAIL busy_ignore_result: got %0d (done=%0b) want %0d", result, done, mres);
        end
        nvec++;
        if (din_log.size() - idx0 != exp_din.size()) begin
            nerr++;
            $display("FAIL busy_ignore_txns: got %0d want %0d", din_log.size() - idx0, exp_din.size());
        end
        repeat (4) @(negedge clk);
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL busy_ignore_restart: busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        logic        busy1, got;
        int          cyc, idx0, ntx, ndone;
        stub_slow = 1'b1;
        @(negedge clk);
        base_v = 32'd2; exp_v = 32'd10; mod_v = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (mod_rdy !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);   // design now waits for rdy high
        nvec++;
        if (mod_en !== 1'b1) begin
            nerr++;
            $display("FAIL rstmid_setup: mod_en got %b want 1", mod_en);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (mod_en !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_async: mod_en=%b busy=%b want 0 0", mod_en, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        stub_slow = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        nvec++;
        if (ndone != 0) begin
            nerr++;
            $display("FAIL rstmid_no_done: got %0d done pulses want 0", ndone);
        end
        run_op(32'd2, 32'd10, 32'd1000, res, cyc, busy1, got, idx0, ntx);
        nvec++;
        if (!got || res !== 32'd24) begin
            nerr++;
            $display("FAIL rstmid_rerun: got %0d (done=%0b) want 24", res, got);
        end
    endtask

`ifdef MODEXP_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, ndone;
        hold_rdy = 1'b1;
        @(negedge clk);
        base_v = $urandom; exp_v = $urandom; mod_v = 32'd12345; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        ndone = 0;
        while (err !== 1'b1 && cyc < 1200) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            cyc++;
        end
        nvec++;
        if (err !== 1'b1 || cyc != 1025) begin
            nerr++;
            $display("FAIL timeout_err: err=%b after %0d cycles want 1 after 1025", err, cyc);
        end
        nvec++;
        if (mod_en !== 1'b0 || busy !== 1'b0 || ndone != 0 || result !== 32'd24) begin
            nerr++;
            $display("FAIL timeout_state: mod_en=%b busy=%b dones=%0d result=%0d want 0 0 0 24", mod_en, busy, ndone, result);
        end
        @(negedge clk);
        nvec++;
        if (err !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_pulse: err got %b want 0", err);
        end
        hold_rdy = 1'b0;
    endtask
`else
    task automatic test_no_err();
        nvec++;
        if (err_hi != 0) begin
            nerr++;
            $display("FAIL err_tied_low: got %0d err cycles want 0", err_hi);
        end
    endtask
`endif

    task automatic test_protocol();
        nvec++;
        if (proto_err != 0) begin
            nerr++;
            $display("FAIL engine_protocol: got %0d operand changes while requested want 0", proto_err);
        end
        nvec++;
        if (both_hi != 0) begin
            nerr++;
            $display("FAIL done_err_overlap: got %0d cycles want 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_trivial_modulus();
        test_random();
        test_start_while_busy();
        test_reset_mid_op();
`ifdef MODEXP_TIMEOUT_EN
        test_timeout();
`else
        test_no_err();
`endif
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_modexp32
`default_nettype wire

// File: doc/modexp32.md
MODEXP32 -- requirements
Module: modexp32

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous, active-high.
REQ-003 SHALL have port start, input, 1: request pulse, sampled only in IDLE.
REQ-004 SHALL have ports base, exp, modulus, input, 32 each: operands, captured on accepted start.
REQ-005 SHALL have port busy, output, 1: high from the cycle after accepted start until done.
REQ-006 SHALL have port done, output, 1: one-cycle pulse when result is valid.
REQ-007 SHALL have port result, output, 32: base^exp mod modulus, held until next done.
REQ-008 SHALL have port err, output, 1: one-cycle pulse on engine timeout.
REQ-009 SHALL have port mod_en, output, 1: level request to the external mod64 engine.
REQ-010 SHALL have ports mod_din and mod_m, output, 64: engine operands, stable while mod_en high.
REQ-011 SHALL have port mod_rdy, input, 1: engine ready, high idle, low while computing.
REQ-012 SHALL have port mod_out, input, 64: engine remainder, valid when mod_rdy returns high.

Function
REQ-013 SHALL act as the initiator of the mod64 en/rdy handshake: assert mod_en with operands; wait mod_rdy==0; wait mod_rdy==1; capture mod_out[31:0]; deassert mod_en for exactly one cycle (REL) before any next request.
REQ-014 SHALL use FSM states IDLE, REQ (mod_en=1, wait rdy low), WAIT (wait rdy high), REL (mod_en=0, select next op), DONE (done=1, one cycle, then IDLE).
REQ-015 SHALL track op in {RED, MUL, SQR}: RED computes base mod m; MUL computes r*b mod m; SQR computes b*b mod m; products are 32x32->64, zero-extended mod_m.
REQ-016 SHALL run right-to-left square-and-multiply: r=1; b=RED; per exp bit LSB-first: MUL if bit set, then SQR unless remaining exp (after shift) is zero.
REQ-017 SHALL finish with exp==0 after RED: result=1, no MUL/SQR issued.
REQ-018 SHALL treat modulus 0 or 1 as result=0 with no engine transaction; done two cycles after start.
REQ-019 SHALL ignore start while busy; operands are not re-sampled.
REQ-020 SHALL not assert done and err in the same cycle.

Reset
REQ-021 SHALL on rst: FSM to IDLE, mod_en=0, busy=0, done=0, err=0, result=0, mod_din=0, mod_m=0, immediately (asynchronous).
REQ-022 SHALL on reset mid-operation: drop mod_en at once, discard partial r/b, produce no done.

Configuration
REQ-023 SHALL, with MODEXP_TIMEOUT_EN defined, count cycles in REQ+WAIT per transaction; at 1024 abort: mod_en=0, err pulse, busy=0, return to IDLE, result unchanged.
REQ-024 SHALL, without MODEXP_TIMEOUT_EN, contain no counter, tie err to 0, and wait indefinitely.

Structure
REQ-025 SHALL place state enum, op enum, OPW=32, TIMEOUT_CYCLES=1024 in package modexp_pkg.
REQ-026 SHALL contain no sub-module; the mod64 engine is instantiated beside it in the parent.

Verification
REQ-027 SHALL check base=4, exp=13, modulus=497 -> result=445, exactly 7 engine transactions (1 RED, 3 MUL, 3 SQR).
REQ-028 SHALL check base=2, exp=10, modulus=1000 -> 24; base=3, exp=0, modulus=7 -> 1.
REQ-029 SHALL check base=0xFFFFFFFF, exp=2, modulus=0xFFFFFFFB -> 16.
REQ-030 SHALL check modulus=0 and modulus=1 -> result=0, mod_en never asserted, done 2 cycles after start.
REQ-031 SHALL check rst asserted while in WAIT -> mod_en low same cycle, no done; next start 2,10,1000 -> 24.
REQ-032 SHALL check (MODEXP_TIMEOUT_EN) engine stub holding mod_rdy high -> err pulse after 1024 cycles, mod_en low, busy low.
